// File: rtl/kernel_st_packet_arbiter.sv
// Packet-locked round-robin merge of NUM_IN Avalon-ST sources into one fully
// registered stream that carries the source index as its channel.
//
// state | meaning
// IDLE  | no lock held; pick the next valid & enabled source
// PKT   | locked to grant_q until its EOP beat is accepted
module kernel_st_packet_arbiter #(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2,
  parameter int CH_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_startofpacket,
  input  logic [NUM_IN-1:0]         in_endofpacket,
  input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
  input  logic [NUM_IN-1:0]         in_enable,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic [CH_W-1:0]           out_channel,
  output logic                      busy
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    grant_q, grant_d;
  logic [CH_W-1:0]    last_grant_q, last_grant_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;
  logic [EMPTY_W-1:0] out_empty_q, out_empty_d;
  logic [CH_W-1:0]    out_channel_q, out_channel_d;
  logic               busy_q, busy_d;

  logic [NUM_IN-1:0]  req;
  logic [CH_W-1:0]    sel_hi, sel_lo, sel;
  logic               found_hi;
  logic               load;
  logic               accept;
  logic [DATA_W-1:0]  grant_data;
  logic [EMPTY_W-1:0] grant_empty;

  assign req         = in_valid & in_enable;
  assign load        = out_ready | ~out_valid_q;
  assign grant_data  = in_data[int'(grant_q)*DATA_W +: DATA_W];
  assign grant_empty = in_empty[int'(grant_q)*EMPTY_W +: EMPTY_W];

  // Lowest requester above last_grant wins; otherwise wrap to the lowest overall.
  always_comb begin
    sel_hi   = '0;
    sel_lo   = '0;
    found_hi = 1'b0;
    for (int i = NUM_IN-1; i >= 0; i--) begin
      if (req[i]) begin
        sel_lo = CH_W'(i);
        if (CH_W'(i) > last_grant_q) begin
          sel_hi   = CH_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    in_ready      = '0;
    accept        = 1'b0;
    out_valid_d   = out_ready ? 1'b0 : out_valid_q;
    out_data_d    = out_data_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_empty_d   = out_empty_q;
    out_channel_d = out_channel_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = sel;
          state_d = PKT;
        end
      end
      PKT: begin
        in_ready[grant_q] = load;
        accept            = in_valid[grant_q] & load;
        if (accept) begin
          out_valid_d   = 1'b1;
          out_data_d    = grant_data;
          out_sop_d     = in_startofpacket[grant_q];
          out_eop_d     = in_endofpacket[grant_q];
          out_empty_d   = grant_empty;
          out_channel_d = grant_q;
          if (in_endofpacket[grant_q]) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == PKT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= CH_W'(NUM_IN-1);
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_empty_q   <= '0;
      out_channel_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_empty_q   <= out_empty_d;
      out_channel_q <= out_channel_d;
      busy_q        <= busy_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_empty         = out_empty_q;
  assign out_channel       = out_channel_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_kernel_st_packet_arbiter.sv
// Scoreboard bench for kernel_st_packet_arbiter: per-source packet lists, a
// packet-level round-robin model, and a monitor comparing every output beat.
`timescale 1ns/1ps
module tb_kernel_st_packet_arbiter;
  localparam int NUM_IN = 4;
  localparam int MAXB   = 256;
  localparam int MAXP   = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   in_valid = '0, in_sop = '0, in_eop = '0, in_enable = '1;
  logic [3:0]   in_ready;
  logic [127:0] in_data = '0;
  logic [7:0]   in_empty = '0;
  logic         out_ready = 1'b1;
  logic         out_valid, out_sop, out_eop, busy;
  logic [31:0]  out_data;
  logic [1:0]   out_empty, out_channel;

  always #5 clk = ~clk;

  kernel_st_packet_arbiter #(.NUM_IN(4), .DATA_W(32), .EMPTY_W(2), .CH_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
    .in_enable(in_enable), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_startofpacket(out_sop), .out_endofpacket(out_eop),
    .out_empty(out_empty), .out_channel(out_channel), .busy(busy)
  );

  typedef struct {
    logic [31:0] data; logic sop; logic eop; logic [1:0] empty; int gap;
  } beat_t;
  typedef struct {
    logic [31:0] data; logic sop; logic eop; logic [1:0] empty; logic [1:0] ch;
  } exp_t;

  beat_t mem [NUM_IN][MAXB];
  int    tail [NUM_IN];
  int    npkt [NUM_IN];
  int    pstart [NUM_IN][MAXP];
  exp_t  exp_q[$];
  exp_t  e;

  int checks = 0, errors = 0;
  bit mon_en = 0, bub_chk = 0;
  int cyc = 0, last_out = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every accepted output beat.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got ch %0d data %0h, required no beat", out_channel, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {out_channel, out_empty, out_sop, out_eop, out_data},
                      {e.ch, e.empty, e.sop, e.eop, e.data});
          if (bub_chk && last_out >= 0) chk("beat_spacing", 64'(cyc - last_out), out_sop ? 2 : 1);
          last_out = cyc;
        end
      end
      if (out_valid && !out_ready) chk("ready_under_backpressure", in_ready, 0);
    end
  end

  task automatic do_reset();
    mon_en = 0; in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
    in_enable = '1; out_ready = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin tail[i] = 0; npkt[i] = 0; end
    exp_q.delete();
    @(posedge clk); #2; reset = 1'b1;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_fields", {out_data, out_sop, out_eop, out_empty, out_channel}, 0);
    chk("reset_busy_ready", {busy, in_ready}, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic add_pkt(input int src, input int len, input bit pat, input int gap_max);
    beat_t x;
    pstart[src][npkt[src]] = tail[src];
    npkt[src]++;
    for (int b = 0; b < len; b++) begin
      x.data  = pat ? (32'hA000_0000 | 32'(src << 8) | 32'(b)) : $urandom;
      x.sop   = (b == 0);
      x.eop   = (b == len - 1);
      x.empty = pat ? 2'd0 : 2'($urandom_range(0, 3));
      x.gap   = (b > 0 && gap_max > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, gap_max)) : 0;
      mem[src][tail[src]] = x;
      tail[src]++;
    end
  endtask

  // Packet-level model: each decision grants the next pending enabled source
  // after the previous winner; dis (if >= 0) loses its enable once granted.
  task automatic build_expected(input logic [3:0] en, input int dis);
    int ptr;
    int nxt [NUM_IN];
    logic [3:0] m;
    int win, s, j;
    bit done;
    exp_t x;
    ptr = NUM_IN - 1; m = en; done = 0;
    for (int i = 0; i < NUM_IN; i++) nxt[i] = 0;
    while (!done) begin
      win = -1;
      for (int k = 1; k <= NUM_IN; k++) begin
        s = (ptr + k) % NUM_IN;
        if (win < 0 && m[s] && nxt[s] < npkt[s]) win = s;
      end
      if (win < 0) done = 1;
      else begin
        j = pstart[win][nxt[win]];
        do begin
          x.data = mem[win][j].data; x.sop = mem[win][j].sop; x.eop = mem[win][j].eop;
          x.empty = mem[win][j].empty; x.ch = 2'(win);
          exp_q.push_back(x);
          j++;
        end while (!mem[win][j-1].eop);
        nxt[win]++;
        ptr = win;
        if (win == dis) m[win] = 1'b0;
      end
    end
  endtask

  // ormode: 0 = out_ready held high, 1 = pattern 1,0,0,1, 2 = random.
  task automatic run_phase(input string name, input logic [3:0] en, input int dis,
                           input int ormode, input bit bub, input int abort_at);
    int head [NUM_IN];
    int gapl [NUM_IN];
    logic [3:0] hs;
    int quiet, n;
    bit stop;
    quiet = 0; n = 0; stop = 0;
    build_expected(en, dis);
    for (int i = 0; i < NUM_IN; i++) begin head[i] = 0; gapl[i] = 0; end
    in_enable = en; bub_chk = bub; last_out = -1; mon_en = 1;
    @(posedge clk); #1;
    while (!stop) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (head[i] < tail[i] && gapl[i] == 0) begin
          in_valid[i] = 1'b1;
          in_data[i*32 +: 32] = mem[i][head[i]].data;
          in_sop[i] = mem[i][head[i]].sop;
          in_eop[i] = mem[i][head[i]].eop;
          in_empty[i*2 +: 2] = mem[i][head[i]].empty;
        end else begin
          in_valid[i] = 1'b0;
          in_data[i*32 +: 32] = $urandom;
        end
      end
      case (ormode)
        0: out_ready = 1'b1;
        1: out_ready = (n % 4 == 0) || (n % 4 == 3);
        default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
      if (abort_at > 0 && n == abort_at) begin
        #3; reset = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_fields", {out_data, out_sop, out_eop, out_empty, out_channel}, 0);
        chk("abort_busy_ready", {busy, in_ready}, 0);
        exp_q.delete();
        stop = 1;
      end else begin
        @(negedge clk);
        hs = in_valid & in_ready;
        @(posedge clk); #1;
        for (int i = 0; i < NUM_IN; i++) begin
          if (hs[i]) begin
            head[i]++;
            gapl[i] = (head[i] < tail[i]) ? mem[i][head[i]].gap : 0;
            if (i == dis) in_enable[i] = 1'b0;
          end else if (gapl[i] > 0) gapl[i]--;
        end
        n++;
        if (exp_q.size() == 0) quiet++;
        if (quiet > 10) stop = 1;
        else if (n > 4000) begin
          checks++; errors++;
          $display("FAIL %s_timeout: %0d beats still pending, required 0", name, exp_q.size());
          exp_q.delete();
          stop = 1;
        end
      end
    end
    mon_en = 0;
  endtask

  initial begin
    logic [3:0] en;
    do_reset();

    // Latency and single-beat return to IDLE, driven by hand.
    @(posedge clk); #1;
    in_valid[0] = 1'b1; in_sop[0] = 1'b1; in_eop[0] = 1'b1;
    in_data[31:0] = 32'h1234_5678; in_empty[1:0] = 2'd1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pkt_busy", busy, 1);
    chk("pkt_in_ready", in_ready, 4'b0001);
    chk("latency_cycle1_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = '0; in_sop = '0; in_eop = '0;
    @(negedge clk);
    chk("latency_cycle2_valid", out_valid, 1);
    chk("single_beat_fields", {out_channel, out_empty, out_sop, out_eop, out_data},
                              {2'd0, 2'd1, 1'b1, 1'b1, 32'h1234_5678});
    chk("single_beat_idle", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("output_drained", out_valid, 0);

    do_reset();
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < NUM_IN; s++) add_pkt(s, 3, 1, 0);
    run_phase("round_robin", 4'hF, -1, 0, 1, 0);

    do_reset();
    add_pkt(1, 5, 0, 0);
    run_phase("backpressure", 4'hF, -1, 1, 0, 0);

    do_reset();
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < NUM_IN; s++) add_pkt(s, int'($urandom_range(1, 4)), 0, 2);
    run_phase("mask", 4'b1101, 2, 2, 0, 0);

    do_reset();
    add_pkt(0, 6, 0, 0);
    mem[0][3].gap = 4;
    for (int p = 0; p < 2; p++) begin
      add_pkt(3, 1, 0, 0);
      mem[3][tail[3]-1].empty = 2'd3;
    end
    add_pkt(2, 2, 0, 0);
    run_phase("stall_single", 4'hF, -1, 0, 0, 0);

    do_reset();
    add_pkt(1, 12, 0, 0);
    run_phase("reset_abort", 4'hF, -1, 0, 0, 5);

    do_reset();
    add_pkt(2, 2, 0, 0);
    add_pkt(0, 3, 0, 0);
    add_pkt(0, 1, 0, 0);
    run_phase("after_reset", 4'hF, -1, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int s = 0; s < NUM_IN; s++)
        repeat ($urandom_range(0, 3)) add_pkt(s, int'($urandom_range(1, 6)), 0, 3);
      en = 4'($urandom_range(0, 15));
      run_phase("random", en, -1, 2, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
